// File: rtl/pwm.sv
// ---------------------------------------------------------------------------
// pwm -- fixed-period pulse-width modulator.
//
// A WIDTH-bit counter runs 0 .. 2^WIDTH-2 (period of 2^WIDTH-1 cycles).
// The requested level on din is captured into a shadow duty register only
// at the period boundary, so every period is generated from one stable
// duty value and no truncated or stretched pulses can occur.
//
// Ports:
//   clk    system clock, all state updates on its rising edge
//   rst_n  asynchronous active-low reset (clears counter and duty)
//   din    requested duty level, 0 = always low, 2^WIDTH-1 = always high
//   sout   PWM output, high for the first 'duty' cycles of each period
// ---------------------------------------------------------------------------
module pwm #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   output logic             sout
);

   // Last count of a period; the all-ones value is never reached, which is
   // what lets duty = 2^WIDTH-1 keep sout high on every cycle.
   localparam logic [WIDTH-1:0] CNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};
   localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] cnt_r;
   logic [WIDTH-1:0] duty_r;
   logic [WIDTH-1:0] cnt_nxt_s;
   logic [WIDTH-1:0] duty_nxt_s;
   logic             at_last_s;

   // Next-state logic: wrap the counter and capture din at the period boundary.
   always_comb begin
      at_last_s  = (cnt_r == CNT_LAST);
      cnt_nxt_s  = cnt_r;
      duty_nxt_s = duty_r;
      if (at_last_s) begin
         cnt_nxt_s  = CNT_ZERO;
         duty_nxt_s = din;
      end else begin
         cnt_nxt_s  = cnt_r + CNT_ONE;
         duty_nxt_s = duty_r;
      end
   end

   // Counter and shadow duty registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r  <= CNT_ZERO;
         duty_r <= CNT_ZERO;
      end else begin
         cnt_r  <= cnt_nxt_s;
         duty_r <= duty_nxt_s;
      end
   end

   // Output decode from flops only; reset clears both operands, so sout
   // falls immediately when rst_n is asserted.
   assign sout = (cnt_r < duty_r);

endmodule

// File: tb/tb_pwm.sv
// ---------------------------------------------------------------------------
// tb_pwm -- self-checking bench for pwm (WIDTH = 8, period 255 cycles).
//
// A behavioural model tracks the number of clock edges since reset and the
// duty value in force for the current period; the position in the period is
// just (edges mod 255). A compare process checks sout against that model on
// every falling edge, and directed sequences check the high count of whole
// periods against hand-computed literals.
// ---------------------------------------------------------------------------
module tb_pwm;

   localparam int W      = 8;
   localparam int PERIOD = 255;

   logic         clk;
   logic         rst_n;
   logic [W-1:0] din;
   logic         sout;

   int checks   = 0;
   int failures = 0;
   int cyc_checks   = 0;
   int cyc_failures = 0;
   bit chk_en       = 1'b0;

   // Model state: edges since reset release and duty of the current period.
   int m_edges = 0;
   int m_duty  = 0;

   pwm #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (din),
      .sout  (sout)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural model: din seen at the edge ending a period sets the next duty.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_edges <= 0;
         m_duty  <= 0;
      end else begin
         if ((m_edges % PERIOD) == PERIOD - 1) m_duty <= int'(din);
         m_edges <= m_edges + 1;
      end
   end

   // Per-cycle comparison of sout against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         automatic bit exp_s = rst_n ? ((m_edges % PERIOD) < m_duty) : 1'b0;
         cyc_checks++;
         if (sout !== exp_s) begin
            cyc_failures++;
            if (cyc_failures <= 20)
               $display("FAIL cycle_model t=%0t pos=%0d duty=%0d sout=%b expected=%b",
                        $time, m_edges % PERIOD, m_duty, sout, exp_s);
         end
      end
   end

   // Safety net so the bench can never hang.
   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Assert reset with din held, check the cleared state, release on a falling edge.
   task automatic do_reset(input logic [W-1:0] d);
      @(negedge clk);
      din   = d;
      rst_n = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("reset_sout", int'(sout), 0);
         chk("reset_cnt", int'(dut.cnt_r), 0);
      end
      rst_n = 1'b1;
   endtask

   // Count high cycles over one full period starting at the current falling
   // edge (which must be period position 0); optionally change din mid-period.
   task automatic count_period(input int chg_pos, input logic [W-1:0] chg_val,
                               output int hi);
      hi = 0;
      for (int i = 0; i < PERIOD; i++) begin
         if (i == chg_pos) din = chg_val;
         hi += int'(sout);
         @(negedge clk);
      end
   endtask

   task automatic check_period(input string name, input int exp);
      int hi;
      count_period(-1, '0, hi);
      chk(name, hi, exp);
   endtask

   initial begin
      int hi;
      int prev;
      rst_n = 1'b0;
      din   = 8'd0;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;

      // Reset with din=200, then din=0 for three periods.
      do_reset(8'd200);
      din = 8'd0;
      for (int p = 0; p < 3; p++) check_period("din0_period", 0);

      // din=255: first period low, then fully high.
      do_reset(8'd255);
      check_period("din255_first", 0);
      for (int p = 0; p < 3; p++) check_period("din255_high", 255);

      // Asynchronous reset mid-period while sout is high.
      repeat (37) @(negedge clk);
      chk("pre_async_sout", int'(sout), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset_sout", int'(sout), 0);
      chk("async_reset_cnt", int'(dut.cnt_r), 0);

      // din=64 held.
      do_reset(8'd64);
      check_period("din64_first", 0);
      check_period("din64_p1", 64);
      check_period("din64_p2", 64);

      // din changes to 200 at position 100: current period keeps 64.
      count_period(100, 8'd200, hi);
      chk("midchange_keep", hi, 64);
      check_period("midchange_next", 200);

      // Narrowest and widest non-trivial pulses.
      din = 8'd1;
      check_period("din1_transition", 200);
      check_period("din1_p1", 1);
      check_period("din1_p2", 1);
      din = 8'd254;
      check_period("din254_transition", 1);
      check_period("din254_p1", 254);
      check_period("din254_p2", 254);

      // Sweep all levels; each period shows the level set one period earlier.
      prev = 254;
      for (int v = 0; v < 256; v++) begin
         din = 8'(v);
         count_period(-1, '0, hi);
         chk("sweep", hi, prev);
         prev = v;
      end
      check_period("sweep_last", 255);

      // A few random levels with random mid-period changes, model-checked per cycle.
      for (int r = 0; r < 8; r++) begin
         count_period(int'($urandom_range(1, PERIOD - 1)), 8'($urandom_range(0, 255)), hi);
      end

      chk_en = 1'b0;
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d",
               checks + cyc_checks, failures + cyc_failures);
      $finish;
   end

endmodule
